bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between the binary counters/arithmetic results (stopwatch count, calculator result) and the per-digit 7-segment decoders. Each digit it produces is a 4-bit code that the decoder renders directly: 0-9 are digits, 4'hA is a dash, 4'hB is blank. It replaces combinational /1000, /100, %10 chains with a small multi-cycle datapath and a start/done handshake.

---
 rtl/bin2bcd_seq_if.sv | 29 ++
 rtl/bin2bcd_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Brief    : Start/done handshake and result bus of the binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int W      = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin, blank_lz,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin, blank_lz,
    output busy, done, bcd, overflow
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  wire logic     CLOCK_50,
  input  wire logic     RST,
  bin2bcd_seq_if.slave  bus
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int          BW      = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(W + 1);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [W-1:0]     r_src, w_src_n;
  logic [BW-1:0]    r_scr, w_scr_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_ovf_l, w_ovf_n;
  logic             r_lz_l, w_lz_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic [BW-1:0]    r_bcd, w_bcd_n;
  logic             r_overflow, w_overflow_n;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scr_sh;
  logic [BW-1:0]    w_fmt;
  logic             w_seen;

  // Add-3 on every nibble of 5 or more; top-nibble carries are dropped on purpose.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_scr[4*d +: 4] >= 4'd5) ? r_scr[4*d +: 4] + 4'd3
                                                        : r_scr[4*d +: 4];
  end

  if (BW > 1) begin : g_shift_wide
    assign w_scr_sh = {w_adj[BW-2:0], r_src[W-1]};
  end else begin : g_shift_narrow
    assign w_scr_sh = r_src[W-1];
  end

  always_comb begin
    w_fmt  = w_scr_sh;
    w_seen = 1'b0;
    if (r_ovf_l) begin
      w_fmt = {DIGITS{4'hA}};
    end else if (r_lz_l) begin
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (!w_seen && (w_scr_sh[4*d +: 4] == 4'd0)) begin
          w_fmt[4*d +: 4] = 4'hB;
        end else begin
          w_seen = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_src_n      = r_src;
    w_scr_n      = r_scr;
    w_cnt_n      = r_cnt;
    w_ovf_n      = r_ovf_l;
    w_lz_n       = r_lz_l;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_bcd_n      = r_bcd;
    w_overflow_n = r_overflow;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_n = SHIFT;
          w_src_n   = bus.bin;
          w_scr_n   = '0;
          w_cnt_n   = CNT_W'(W);
          w_ovf_n   = (64'(bus.bin) > MAX_VAL);
          w_lz_n    = bus.blank_lz;
          w_busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        w_src_n = r_src << 1;
        w_scr_n = w_scr_sh;
        w_cnt_n = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_n    = IDLE;
          w_busy_n     = 1'b0;
          w_done_n     = 1'b1;
          w_bcd_n      = w_fmt;
          w_overflow_n = r_ovf_l;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_state    <= IDLE;
      r_src      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_l    <= 1'b0;
      r_lz_l     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_src      <= w_src_n;
      r_scr      <= w_scr_n;
      r_cnt      <= w_cnt_n;
      r_ovf_l    <= w_ovf_n;
      r_lz_l     <= w_lz_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_bcd      <= w_bcd_n;
      r_overflow <= w_overflow_n;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
